// File: rtl/pht_pkg.sv
// Shared definitions for the pattern-history-table branch predictor.
// Holds the default parameter values and helpers that derive the
// saturating-counter reset value (weakly taken) and saturation limit
// from the counter width.
package pht_pkg;

  localparam int unsigned DefCtrBits  = 2;
  localparam int unsigned DefIdxBits  = 6;
  localparam int unsigned DefHistBits = 6;

  // Weakly-taken reset value: only the counter MSB set.
  function automatic int unsigned ctr_reset_val(input int unsigned bits);
    return 32'd1 << (bits - 32'd1);
  endfunction

  // Saturation limit: all counter bits set.
  function automatic int unsigned ctr_max_val(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter, one per table entry.
// Ports:
//   clk    - clock, state changes on the rising edge
//   reset  - asynchronous active-low reset, loads the weakly-taken value
//   inc    - count up, holds at the maximum
//   dec    - count down, holds at zero
//   value  - current counter value
module sat_counter
  import pht_pkg::*;
#(
  parameter int unsigned CTR_BITS = DefCtrBits
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                dec,
  output logic [CTR_BITS-1:0] value
);

  localparam logic [CTR_BITS-1:0] CtrRst = CTR_BITS'(ctr_reset_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CtrMax = CTR_BITS'(ctr_max_val(CTR_BITS));

  logic [CTR_BITS-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc && !dec) begin
      if (value_q != CtrMax) value_d = value_q + CTR_BITS'(1);
    end else if (dec && !inc) begin
      if (value_q != '0) value_d = value_q - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) value_q <= CtrRst;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/pht_predictor.sv
// Global-history (gshare) pattern history table branch predictor.
// A table of 2^IDX_BITS saturating counters is indexed by PC[IDX_BITS+1:2]
// XOR the global history register; HIST_BITS=0 gives a plain bimodal table.
// Ports:
//   clk          - clock
//   reset        - asynchronous active-low reset
//   lookup_valid - lookup request this cycle
//   lookup_pc    - branch address to predict
//   update_valid - resolved branch update this cycle
//   update_idx   - table index returned by the matching lookup
//   update_taken - resolved direction, 1 = taken
//   pred_valid   - prediction/pred_idx valid (one cycle after lookup)
//   prediction   - predicted direction, 1 = taken
//   pred_idx     - index used, carried with the branch for update
//   ghr          - global history, LSB = most recent outcome
module pht_predictor
  import pht_pkg::*;
#(
  parameter int unsigned CTR_BITS  = DefCtrBits,
  parameter int unsigned IDX_BITS  = DefIdxBits,
  parameter int unsigned HIST_BITS = DefHistBits
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   lookup_valid,
  input  logic [31:0]                            lookup_pc,
  input  logic                                   update_valid,
  input  logic [IDX_BITS-1:0]                    update_idx,
  input  logic                                   update_taken,
  output logic                                   pred_valid,
  output logic                                   prediction,
  output logic [IDX_BITS-1:0]                    pred_idx,
  output logic [((HIST_BITS > 0) ? HIST_BITS : 1)-1:0] ghr
);

  localparam int unsigned NumEntries = 1 << IDX_BITS;
  localparam int unsigned GhrW       = (HIST_BITS > 0) ? HIST_BITS : 1;
  localparam logic [CTR_BITS-1:0] CtrMax = CTR_BITS'(ctr_max_val(CTR_BITS));

  logic [CTR_BITS-1:0] ctr_val [NumEntries];

  for (genvar i = 0; i < NumEntries; i++) begin : gen_ctr
    logic hit;
    assign hit = update_valid && (update_idx == IDX_BITS'(i));
    sat_counter #(
      .CTR_BITS(CTR_BITS)
    ) u_ctr (
      .clk  (clk),
      .reset(reset),
      .inc  (hit && update_taken),
      .dec  (hit && !update_taken),
      .value(ctr_val[i])
    );
  end

  logic [GhrW-1:0]     ghr_q, ghr_d;
  logic [IDX_BITS-1:0] hist_ext;
  logic [IDX_BITS-1:0] lookup_idx;
  logic [CTR_BITS-1:0] rd_val;
  logic                pred_valid_q, prediction_q;
  logic [IDX_BITS-1:0] pred_idx_q;

  // Only PC[IDX_BITS+1:2] feeds the hash.
  logic unused_pc;
  assign unused_pc = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0]};

  always_comb begin
    hist_ext = '0;
    if (HIST_BITS > 0) hist_ext = IDX_BITS'(ghr_q);
    // Pre-update history is used even when an update lands this cycle.
    lookup_idx = lookup_pc[IDX_BITS+1:2] ^ hist_ext;
  end

  always_comb begin
    ghr_d = ghr_q;
    if (update_valid && (HIST_BITS > 0)) ghr_d = (ghr_q << 1) | GhrW'(update_taken);
  end

  // Write-first bypass: a same-cycle update to the looked-up entry is
  // reflected in the prediction.
  always_comb begin
    rd_val = ctr_val[lookup_idx];
    if (update_valid && (update_idx == lookup_idx)) begin
      if (update_taken) begin
        if (rd_val != CtrMax) rd_val = rd_val + CTR_BITS'(1);
      end else if (rd_val != '0) begin
        rd_val = rd_val - CTR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      prediction_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      ghr_q        <= ghr_d;
      pred_valid_q <= lookup_valid;
      if (lookup_valid) begin
        prediction_q <= rd_val[CTR_BITS-1];
        pred_idx_q   <= lookup_idx;
      end
    end
  end

  assign pred_valid = pred_valid_q;
  assign prediction = prediction_q;
  assign pred_idx   = pred_idx_q;
  assign ghr        = ghr_q;

endmodule

// File: tb/tb_pht_predictor.sv
module tb_pht_predictor;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // DUT a: defaults (CTR 2, IDX 6, HIST 6)
  logic        lv_a = 0, uv_a = 0, ut_a = 0;
  logic [31:0] pc_a = 0;
  logic [5:0]  uidx_a = 0;
  logic        pv_a, pr_a;
  logic [5:0]  pidx_a, ghr_a;

  // DUT b: bimodal, CTR 3
  logic        lv_b = 0, uv_b = 0, ut_b = 0;
  logic [31:0] pc_b = 0;
  logic [5:0]  uidx_b = 0;
  logic        pv_b, pr_b;
  logic [5:0]  pidx_b;
  logic [0:0]  ghr_b;

  pht_predictor u_dut_a (
    .clk(clk), .reset(rst_n), .lookup_valid(lv_a), .lookup_pc(pc_a),
    .update_valid(uv_a), .update_idx(uidx_a), .update_taken(ut_a),
    .pred_valid(pv_a), .prediction(pr_a), .pred_idx(pidx_a), .ghr(ghr_a)
  );

  pht_predictor #(.CTR_BITS(3), .IDX_BITS(6), .HIST_BITS(0)) u_dut_b (
    .clk(clk), .reset(rst_n), .lookup_valid(lv_b), .lookup_pc(pc_b),
    .update_valid(uv_b), .update_idx(uidx_b), .update_taken(ut_b),
    .pred_valid(pv_b), .prediction(pr_b), .pred_idx(pidx_b), .ghr(ghr_b)
  );

  typedef struct packed {
    bit       sel;
    bit       pred;
    bit [5:0] idx;
  } exp_t;

  exp_t sb[$];
  int   ctr_a_m [64];
  int   ctr_b_m [64];
  int   ghr_a_m;
  bit   last_pr_a, last_pr_b;
  bit [5:0] last_idx_a, last_idx_b;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      ctr_a_m[i] = 2;
      ctr_b_m[i] = 4;
    end
    ghr_a_m = 0;
    last_pr_a = 0; last_pr_b = 0;
    last_idx_a = 0; last_idx_b = 0;
    sb.delete();
  endtask

  task automatic clear_inputs();
    lv_a = 0; uv_a = 0; ut_a = 0; pc_a = 0; uidx_a = 0;
    lv_b = 0; uv_b = 0; ut_b = 0; pc_b = 0; uidx_b = 0;
  endtask

  // Async reset asserted mid-cycle; outputs must clear before the next edge,
  // and activity presented during reset must be ignored.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk({tag, "_pv_a"}, {31'b0, pv_a}, 0);
    chk({tag, "_pr_a"}, {31'b0, pr_a}, 0);
    chk({tag, "_pidx_a"}, {26'b0, pidx_a}, 0);
    chk({tag, "_ghr_a"}, {26'b0, ghr_a}, 0);
    chk({tag, "_pv_b"}, {31'b0, pv_b}, 0);
    lv_a = 1; pc_a = 32'h40; uv_a = 1; uidx_a = 6'h10; ut_a = 1;
    lv_b = 1; pc_b = 32'h0c; uv_b = 1; uidx_b = 6'h03; ut_b = 0;
    @(posedge clk);
    #1;
    chk({tag, "_hold_pv_a"}, {31'b0, pv_a}, 0);
    chk({tag, "_hold_ghr_a"}, {26'b0, ghr_a}, 0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    model_reset();
  endtask

  task automatic step(input string tag, input bit sel, input bit lv, input logic [31:0] pc,
                      input bit uv, input logic [5:0] uidx, input bit ut);
    int   idx;
    exp_t e;
    @(negedge clk);
    clear_inputs();
    if (!sel) begin
      lv_a = lv; pc_a = pc; uv_a = uv; uidx_a = uidx; ut_a = ut;
      idx = int'(pc[7:2]) ^ ghr_a_m;
      if (uv) begin
        if (ut && ctr_a_m[uidx] < 3) ctr_a_m[uidx]++;
        if (!ut && ctr_a_m[uidx] > 0) ctr_a_m[uidx]--;
        ghr_a_m = ((ghr_a_m << 1) | int'(ut)) & 63;
      end
      if (lv) begin
        e.sel = 0; e.pred = ctr_a_m[idx][1]; e.idx = 6'(idx);
        sb.push_back(e);
      end
    end else begin
      lv_b = lv; pc_b = pc; uv_b = uv; uidx_b = uidx; ut_b = ut;
      idx = int'(pc[7:2]);
      if (uv) begin
        if (ut && ctr_b_m[uidx] < 7) ctr_b_m[uidx]++;
        if (!ut && ctr_b_m[uidx] > 0) ctr_b_m[uidx]--;
      end
      if (lv) begin
        e.sel = 1; e.pred = ctr_b_m[idx][2]; e.idx = 6'(idx);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (!sel) begin
      chk({tag, "_pv"}, {31'b0, pv_a}, {31'b0, lv});
      if (pv_a === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_sel"}, {31'b0, e.sel}, 0);
        chk({tag, "_pred"}, {31'b0, pr_a}, {31'b0, e.pred});
        chk({tag, "_idx"}, {26'b0, pidx_a}, {26'b0, e.idx});
        last_pr_a = e.pred; last_idx_a = e.idx;
      end else begin
        chk({tag, "_pred_hold"}, {31'b0, pr_a}, {31'b0, last_pr_a});
        chk({tag, "_idx_hold"}, {26'b0, pidx_a}, {26'b0, last_idx_a});
      end
      chk({tag, "_ghr"}, {26'b0, ghr_a}, ghr_a_m);
    end else begin
      chk({tag, "_pv"}, {31'b0, pv_b}, {31'b0, lv});
      if (pv_b === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_sel"}, {31'b0, e.sel}, 1);
        chk({tag, "_pred"}, {31'b0, pr_b}, {31'b0, e.pred});
        chk({tag, "_idx"}, {26'b0, pidx_b}, {26'b0, e.idx});
        last_pr_b = e.pred; last_idx_b = e.idx;
      end else begin
        chk({tag, "_pred_hold"}, {31'b0, pr_b}, {31'b0, last_pr_b});
      end
      chk({tag, "_ghr"}, {31'b0, ghr_b}, 0);
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc;
    logic [5:0]  ui;
    bit          b_lv, b_uv, b_ut;

    model_reset();
    do_reset("rst0");

    // Basic lookup after reset: PC 0x40 -> idx 0x10, weakly taken.
    step("lk40", 0, 1, 32'h40, 0, 0, 0);
    chk("lk40_const_idx", {26'b0, pidx_a}, 32'h10);
    chk("lk40_const_pred", {31'b0, pr_a}, 1);

    // Same-cycle lookup and not-taken update at 0x10: bypass gives 0.
    step("byp_dec", 0, 1, 32'h40, 1, 6'h10, 0);
    chk("byp_dec_const", {31'b0, pr_a}, 0);
    step("byp_inc", 0, 1, 32'h40, 1, 6'h10, 1);

    // Idle cycle: valid drops, outputs hold.
    step("idle", 0, 0, 32'h0, 0, 0, 0);

    // Saturation at idx 5: four taken then five not-taken, with a lookup of
    // idx 5 each cycle (PC chosen against the pre-update history).
    for (int i = 0; i < 9; i++) begin
      pc = 32'((5 ^ ghr_a_m) << 2);
      step($sformatf("sat_a%0d", i), 0, 1, pc, 1, 6'd5, i < 4);
    end

    // Async reset with non-zero counters and history.
    do_reset("rst_mid");
    step("post_rst5", 0, 1, 32'h14, 0, 0, 0);
    step("post_rst10", 0, 1, 32'h40, 0, 0, 0);

    // History 1,0,1,1 -> 0b001011, then lookup PC 0x40 -> idx 0x1B.
    step("h1", 0, 0, 0, 1, 6'd7, 1);
    step("h0", 0, 0, 0, 1, 6'd7, 0);
    step("h2", 0, 0, 0, 1, 6'd7, 1);
    step("h3", 0, 0, 0, 1, 6'd7, 1);
    chk("ghr_1011", {26'b0, ghr_a}, 32'h0b);
    step("hlk", 0, 1, 32'h40, 0, 0, 0);
    chk("hlk_const_idx", {26'b0, pidx_a}, 32'h1b);

    // Random mixed traffic on the gshare instance.
    for (int i = 0; i < 40; i++) begin
      pc   = $urandom;
      b_lv = 1'($urandom_range(0, 1));
      b_uv = 1'($urandom_range(0, 1));
      b_ut = 1'($urandom_range(0, 1));
      ui   = ($urandom_range(0, 1) == 1) ? 6'(int'(pc[7:2]) ^ ghr_a_m) : 6'($urandom);
      step($sformatf("rnd%0d", i), 0, b_lv, pc, b_uv, ui, b_ut);
    end

    // Bimodal 3-bit instance: ten taken at idx 3, then four not-taken.
    for (int i = 0; i < 14; i++) begin
      step($sformatf("bim%0d", i), 1, 1, 32'hABCD_5E0F & 32'hFFFF_FF03 | 32'h0C, 1, 6'd3,
           i < 10);
    end
    chk("bim_idx_const", {26'b0, pidx_b}, 32'h03);
    step("bim_idle", 1, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
